// File: rtl/toa_capture.sv
// toa_capture: first-edge time-of-arrival capture with a 16-bit register bus and event FIFO.
// TOA_DROP_CNT_EN adds an 8-bit saturating dropped-event counter at register 6.
module toa_capture #(
  parameter int N_CH       = 15,
  parameter int TS_W       = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wb_valid_i,
  input  logic [3:0]      wbs_adr_i,
  input  logic [15:0]     wbs_dat_i,
  input  logic            wbs_strb_i,
  output logic            wbs_ack_o,
  output logic [15:0]     wbs_dat_o,
  input  logic [N_CH-1:0] cmp,
  input  logic            ce_pcm,
  input  logic            mclear,
  output logic            irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 4 + TS_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] window;
  logic            irq_en;
  logic            ovf;
  logic            done;
  logic [N_CH-1:0] hitmask;
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] cmp_q;
  logic [TS_W-1:0] snap [N_CH];

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level;

  logic acc;
  logic wr;
  logic rd;
  logic ctrl_wr;
  logic win_wr;
  logic pop_req;

  assign acc     = wb_valid_i & ~wbs_ack_o;
  assign wr      = acc & wbs_strb_i;
  assign rd      = acc & ~wbs_strb_i;
  assign ctrl_wr = wr & (wbs_adr_i == 4'd0);
  assign win_wr  = wr & (wbs_adr_i == 4'd2);
  assign pop_req = rd & (wbs_adr_i == 4'd3);

  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] new_hit;

  assign rise    = cmp & ~cmp_q;
  assign new_hit = (state == S_RUN) ? (rise & ~hitmask) : '0;

  logic            push;
  logic [3:0]      push_ch;
  logic [TS_W-1:0] push_ts;
  logic [N_CH-1:0] push_sel;

  // Downward scan leaves the lowest pending channel selected.
  always_comb begin
    push_ch  = 4'd0;
    push_ts  = '0;
    push_sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        push_ch  = 4'(i);
        push_ts  = snap[i];
        push_sel = '0;
        push_sel[i] = 1'b1;
      end
    end
    push = |pend;
  end

  logic full;
  logic empty;
  logic pop_do;
  logic push_do;
  logic drop;

  assign full    = (level == (AW+1)'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign pop_do  = pop_req & ~empty;
  assign push_do = push & (~full | pop_do);
  assign drop    = push & full & ~pop_do;

`ifdef TOA_DROP_CNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      drop_cnt <= 8'd0;
    end else if (mclear) begin
      drop_cnt <= 8'd0;
    end else if (ctrl_wr && wbs_dat_i[4]) begin
      drop_cnt <= 8'd0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cmp_q <= '0;
    end else begin
      cmp_q <= cmp;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= S_IDLE;
      ts      <= '0;
      window  <= '1;
      irq_en  <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      hitmask <= '0;
      pend    <= '0;
      for (int i = 0; i < N_CH; i++) snap[i] <= '0;
    end else if (mclear) begin
      state   <= S_IDLE;
      ts      <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      hitmask <= '0;
      pend    <= '0;
    end else begin
      pend    <= (pend & ~push_sel) | new_hit;
      hitmask <= hitmask | new_hit;
      for (int i = 0; i < N_CH; i++) begin
        if (new_hit[i]) snap[i] <= ts;
      end
      if (drop) ovf <= 1'b1;
      if (win_wr) window <= wbs_dat_i[TS_W-1:0];
      if (ctrl_wr) begin
        irq_en <= wbs_dat_i[1];
        if (wbs_dat_i[4]) ovf <= 1'b0;
        ts <= '0;
        if (wbs_dat_i[0]) begin
          state   <= S_RUN;
          hitmask <= '0;
          pend    <= '0;
          done    <= 1'b0;
        end else begin
          state <= S_IDLE;
        end
      end else if (state == S_RUN && ce_pcm) begin
        if (ts == window - TS_W'(1)) begin
          state <= S_DONE;
          done  <= 1'b1;
          ts    <= window;
        end else begin
          ts <= ts + TS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_do && !mclear) mem[wr_ptr] <= {push_ch, push_ts};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (mclear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_do) wr_ptr <= wr_ptr + AW'(1);
      if (pop_do) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_do, pop_do})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  logic [15:0] rdata;
  logic        armed;

  assign armed = (state != S_IDLE);

  always_comb begin
    rdata = 16'h0000;
    case (wbs_adr_i)
      4'd0: rdata = {10'd0, done, ovf, state, irq_en, armed};
      4'd1: rdata = 16'(hitmask);
      4'd2: rdata = 16'(window);
      4'd3: rdata = empty ? 16'hF000 : 16'(mem[rd_ptr]);
      4'd4: rdata = 16'(level);
      4'd5: rdata = 16'(ts);
`ifdef TOA_DROP_CNT_EN
      4'd6: rdata = {8'd0, drop_cnt};
`endif
      default: rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 16'h0000;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= rd ? rdata : 16'h0000;
    end
  end

  assign irq_o = irq_en & done;

  logic unused;
  assign unused = ^wbs_dat_i[15:TS_W];

endmodule

// File: tb/tb_toa_capture.sv
// Bench for toa_capture: directed scenarios plus randomized windows
// checked against a per-channel first-arrival model.
module tb_toa_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  adr;
  logic [15:0] dat;
  logic        strb;
  logic        ack;
  logic [15:0] dout;
  logic [14:0] cmp;
  logic        ce;
  logic        mclear;
  logic        irq;

  int tests = 0;
  int fails = 0;

  toa_capture dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_valid_i(valid),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_strb_i(strb),
    .wbs_ack_o (ack),
    .wbs_dat_o (dout),
    .cmp       (cmp),
    .ce_pcm    (ce),
    .mclear    (mclear),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [3:0] a, input logic s,
                     input logic [15:0] d, output logic [15:0] q);
    int n;
    valid = 1'b1;
    adr   = a;
    strb  = s;
    dat   = d;
    n     = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 4);
    chk("bus_ack", {15'd0, ack}, 16'h0001);
    q     = dout;
    valid = 1'b0;
    strb  = 1'b0;
    dat   = 16'h0000;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    logic [15:0] q;
    bus(a, 1'b1, d, q);
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] q);
    bus(a, 1'b0, 16'h0000, q);
  endtask

  task automatic pcm(input int n);
    for (int i = 0; i < n; i++) begin
      ce = 1'b1;
      tick();
      ce = 1'b0;
    end
  endtask

  logic [15:0] q;
  logic [15:0] exp6;
  int          win;
  int          mts;
  bit          running;
  int          exp_ts [16];
  int          got_ts [16];
  int          hits;
  int          bogus;
  int          guard;
  logic [14:0] prev;
  logic [14:0] cur;
  logic [14:0] mask;

  initial begin
    rst_n  = 1'b0;
    valid  = 1'b0;
    adr    = 4'd0;
    dat    = 16'h0000;
    strb   = 1'b0;
    cmp    = '0;
    ce     = 1'b0;
    mclear = 1'b0;
    ticks(2);
    chk("rst_ack", {15'd0, ack}, 16'h0000);
    chk("rst_dout", dout, 16'h0000);
    chk("rst_irq", {15'd0, irq}, 16'h0000);
    rst_n = 1'b1;
    tick();

    rd(4'd0, q); chk("rst_ctrl", q, 16'h0000);
    rd(4'd1, q); chk("rst_hit", q, 16'h0000);
    rd(4'd2, q); chk("rst_window", q, 16'h0FFF);
    rd(4'd3, q); chk("rst_pop", q, 16'hF000);
    rd(4'd4, q); chk("rst_level", q, 16'h0000);
    rd(4'd5, q); chk("rst_tsnow", q, 16'h0000);
    rd(4'd6, q); chk("rst_reg6", q, 16'h0000);
    rd(4'd9, q); chk("unmapped", q, 16'h0000);

    // single channel, repeat edge ignored, window close
    wr(4'd2, 16'd10);
    wr(4'd0, 16'h0003);
    pcm(4);
    cmp[3] = 1'b1; tick(); cmp = '0; tick();
    pcm(2);
    cmp[3] = 1'b1; tick(); cmp = '0; tick();
    rd(4'd4, q); chk("w1_level", q, 16'h0001);
    rd(4'd1, q); chk("w1_hit", q, 16'h0008);
    pcm(3);
    chk("w1_irq_pre", {15'd0, irq}, 16'h0000);
    pcm(1);
    chk("w1_irq", {15'd0, irq}, 16'h0001);
    rd(4'd0, q); chk("w1_ctrl", q, 16'h002B);
    rd(4'd5, q); chk("w1_tsnow", q, 16'h000A);
    pcm(2);
    rd(4'd5, q); chk("w1_frozen", q, 16'h000A);
    rd(4'd3, q); chk("w1_pop", q, 16'h3004);
    rd(4'd4, q); chk("w1_level0", q, 16'h0000);

    // simultaneous edges drain in channel order
    wr(4'd0, 16'h0003);
    chk("w2_irq_clr", {15'd0, irq}, 16'h0000);
    pcm(5);
    cmp = 15'h4081; tick(); cmp = '0;
    ticks(4);
    rd(4'd4, q); chk("w2_level3", q, 16'h0003);
    rd(4'd3, q); chk("w2_pop0", q, 16'h0005);
    rd(4'd4, q); chk("w2_level2", q, 16'h0002);
    rd(4'd3, q); chk("w2_pop1", q, 16'h7005);
    rd(4'd4, q); chk("w2_level1", q, 16'h0001);
    rd(4'd3, q); chk("w2_pop2", q, 16'hE005);
    rd(4'd4, q); chk("w2_level0", q, 16'h0000);
    rd(4'd3, q); chk("w2_pop_empty", q, 16'hF000);

    // overflow across two windows
    wr(4'd0, 16'h0003);
    cmp = 15'h7FFF; tick(); cmp = '0;
    ticks(17);
    wr(4'd0, 16'h0003);
    cmp = 15'h7FFF; tick(); cmp = '0;
    ticks(17);
    rd(4'd4, q); chk("ov_level", q, 16'h0010);
    rd(4'd0, q); chk("ov_ctrl", q, 16'h0017);
`ifdef TOA_DROP_CNT_EN
    exp6 = 16'd14;
`else
    exp6 = 16'd0;
`endif
    rd(4'd6, q); chk("ov_reg6", q, exp6);
    wr(4'd0, 16'h0013);
    rd(4'd0, q); chk("ov_clr", q, 16'h0007);
    rd(4'd6, q); chk("ov_reg6_clr", q, 16'h0000);
    for (int i = 0; i < 15; i++) begin
      rd(4'd3, q); chk("ov_pop", q, 16'(i << 12));
    end
    rd(4'd3, q); chk("ov_pop_last", q, 16'h0000);
    rd(4'd4, q); chk("ov_level0", q, 16'h0000);

    // mclear mid-run
    pcm(2);
    cmp = 15'h0212; tick(); cmp = '0;
    ticks(4);
    rd(4'd4, q); chk("mc_level3", q, 16'h0003);
    mclear = 1'b1; tick(); mclear = 1'b0;
    rd(4'd0, q); chk("mc_ctrl", q, 16'h0002);
    rd(4'd4, q); chk("mc_level", q, 16'h0000);
    rd(4'd1, q); chk("mc_hit", q, 16'h0000);
    rd(4'd2, q); chk("mc_window", q, 16'h000A);
    rd(4'd5, q); chk("mc_tsnow", q, 16'h0000);

    // mclear beats a same-cycle arm
    mclear = 1'b1;
    wr(4'd0, 16'h0003);
    mclear = 1'b0;
    rd(4'd0, q); chk("mc_vs_arm", q, 16'h0002);

    // edge coinciding with ce_pcm
    wr(4'd0, 16'h0003);
    pcm(7);
    cmp[2] = 1'b1; ce = 1'b1; tick(); cmp = '0; ce = 1'b0;
    ticks(2);
    rd(4'd3, q); chk("co_pop", q, 16'h2007);
    rd(4'd5, q); chk("co_tsnow", q, 16'h0008);

    // randomized windows against a first-arrival model
    mclear = 1'b1; tick(); mclear = 1'b0;
    for (int w = 0; w < 5; w++) begin
      win = $urandom_range(40, 6);
      wr(4'd2, 16'(win));
      wr(4'd0, 16'h0003);
      for (int c = 0; c < 16; c++) exp_ts[c] = -1;
      mts = 0;
      running = 1'b1;
      prev = '0;
      guard = 0;
      while (running && guard < 2000) begin
        for (int c = 0; c < 15; c++) cur[c] = ($urandom_range(7, 0) == 0);
        cmp = cur;
        ce = ($urandom_range(2, 0) == 0);
        for (int c = 0; c < 15; c++) begin
          if (cur[c] && !prev[c] && exp_ts[c] < 0) exp_ts[c] = mts;
        end
        if (ce) begin
          mts++;
          if (mts == win) running = 1'b0;
        end
        prev = cur;
        tick();
        guard++;
      end
      cmp = '0;
      ce = 1'b0;
      chk("rnd_done_bound", {15'd0, running}, 16'h0000);
      ticks(20);
      hits = 0;
      mask = '0;
      for (int c = 0; c < 15; c++) begin
        if (exp_ts[c] >= 0) begin
          hits++;
          mask[c] = 1'b1;
        end
      end
      chk("rnd_irq", {15'd0, irq}, 16'h0001);
      rd(4'd5, q); chk("rnd_tsnow", q, 16'(win));
      rd(4'd1, q); chk("rnd_hit", q, {1'b0, mask});
      rd(4'd4, q); chk("rnd_level", q, 16'(hits));
      for (int c = 0; c < 16; c++) got_ts[c] = -1;
      bogus = 0;
      for (int k = 0; k < hits; k++) begin
        rd(4'd3, q);
        if (q[15:12] == 4'hF || got_ts[q[15:12]] >= 0) bogus++;
        else got_ts[q[15:12]] = int'(q[11:0]);
      end
      chk("rnd_bogus", 16'(bogus), 16'h0000);
      for (int c = 0; c < 15; c++) begin
        chk("rnd_ch_ts", 16'(got_ts[c]), 16'(exp_ts[c]));
      end
      rd(4'd4, q); chk("rnd_level0", q, 16'h0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
